copy_sequencer: RTL and testbench



---
 rtl/copy_sequencer_if.sv | 34 +++
 rtl/copy_sequencer.sv | 125 ++++++++++++
 tb/tb_copy_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/copy_sequencer_if.sv
// Bundle of the issue-side request/response handshakes and the copy-unit drive/return lanes.
// The sequencer uses the slave modport; the issue stage and copy unit use master.
interface copy_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_neg;
    logic [3:0]  req_mask;
    logic [1:0]  req_shift;
    logic [31:0] req_src;
    logic [31:0] req_dst;
    logic [31:0] copy_a;
    logic [3:0]  copy_select;
    logic        copy_neg;
    logic [31:0] copy_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_neg, req_mask, req_shift, req_src, req_dst,
        output rsp_ready, copy_y,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  copy_a, copy_select, copy_neg
    );

    modport slave (
        input  req_valid, req_op, req_neg, req_mask, req_shift, req_src, req_dst,
        input  rsp_ready, copy_y,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output copy_a, copy_select, copy_neg
    );
endinterface

// File: rtl/copy_sequencer.sv
// Sequences COPY/MERGE/SPLAT byte-lane operations through the combinational copy unit,
// accumulating one or two passes into a single 32-bit response.
module copy_sequencer #(
    parameter bit SPLAT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    copy_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;

    localparam logic [1:0] OP_MERGE = 2'b01;
    localparam logic [1:0] OP_SPLAT = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] dst_q, dst_d;
    logic        err_q, err_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] copy_a_q, copy_a_d;
    logic [3:0]  copy_select_q, copy_select_d;
    logic        copy_neg_q, copy_neg_d;

    logic        req_reserved;
    logic [31:0] rot_src;
    logic [7:0]  splat_byte;

    assign req_reserved = (bus.req_op == OP_RSVD) || ((bus.req_op == OP_SPLAT) && !SPLAT_EN);
    assign splat_byte   = bus.req_src[{bus.req_shift, 3'b000} +: 8];

    always_comb begin
        unique case (bus.req_shift)
            2'd0:    rot_src = bus.req_src;
            2'd1:    rot_src = {bus.req_src[7:0],  bus.req_src[31:8]};
            2'd2:    rot_src = {bus.req_src[15:0], bus.req_src[31:16]};
            default: rot_src = {bus.req_src[23:0], bus.req_src[31:24]};
        endcase
    end

    // PASS1 operands are computed at accept so the copy unit sees them from flops.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        mask_d        = mask_q;
        dst_d         = dst_q;
        err_d         = err_q;
        acc_d         = acc_q;
        copy_a_d      = '0;
        copy_select_d = '0;
        copy_neg_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    mask_d  = bus.req_mask;
                    dst_d   = bus.req_dst;
                    err_d   = req_reserved;
                    state_d = PASS1;
                    if (!req_reserved) begin
                        copy_select_d = bus.req_mask;
                        copy_neg_d    = bus.req_neg;
                        copy_a_d      = (bus.req_op == OP_SPLAT) ? {4{splat_byte}} : rot_src;
                    end
                end
            end
            PASS1: begin
                acc_d = err_q ? '0 : bus.copy_y;
                if (op_q == OP_MERGE) begin
                    copy_a_d      = dst_q;
                    copy_select_d = ~mask_q;
                    state_d       = PASS2;
                end else begin
                    state_d = DONE;
                end
            end
            PASS2: begin
                acc_d   = acc_q | bus.copy_y;
                state_d = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            mask_q        <= '0;
            dst_q         <= '0;
            err_q         <= 1'b0;
            acc_q         <= '0;
            copy_a_q      <= '0;
            copy_select_q <= '0;
            copy_neg_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            mask_q        <= mask_d;
            dst_q         <= dst_d;
            err_q         <= err_d;
            acc_q         <= acc_d;
            copy_a_q      <= copy_a_d;
            copy_select_q <= copy_select_d;
            copy_neg_q    <= copy_neg_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_data    = (state_q == DONE) ? acc_q : '0;
    assign bus.rsp_err     = (state_q == DONE) && err_q;
    assign bus.copy_a      = copy_a_q;
    assign bus.copy_select = copy_select_q;
    assign bus.copy_neg    = copy_neg_q;

endmodule

// File: tb/tb_copy_sequencer.sv
// Drives a SPLAT-enabled and a SPLAT-disabled copy_sequencer with identical stimulus and
// checks both against a byte-lane reference model plus a behavioural copy unit.
module tb_copy_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_neg;
    logic [3:0]  req_mask;
    logic [1:0]  req_shift;
    logic [31:0] req_src;
    logic [31:0] req_dst;
    logic        rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    copy_sequencer_if bus0 ();
    copy_sequencer_if bus1 ();

    copy_sequencer #(.SPLAT_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    copy_sequencer #(.SPLAT_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [31:0] copy_unit(input logic [31:0] a, input logic [3:0] sel, input logic neg);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 4; i++)
            if (sel[i]) y[8*i +: 8] = neg ? ~a[8*i +: 8] : a[8*i +: 8];
        return y;
    endfunction

    assign bus0.req_valid = req_valid;  assign bus1.req_valid = req_valid;
    assign bus0.req_op    = req_op;     assign bus1.req_op    = req_op;
    assign bus0.req_neg   = req_neg;    assign bus1.req_neg   = req_neg;
    assign bus0.req_mask  = req_mask;   assign bus1.req_mask  = req_mask;
    assign bus0.req_shift = req_shift;  assign bus1.req_shift = req_shift;
    assign bus0.req_src   = req_src;    assign bus1.req_src   = req_src;
    assign bus0.req_dst   = req_dst;    assign bus1.req_dst   = req_dst;
    assign bus0.rsp_ready = rsp_ready;  assign bus1.rsp_ready = rsp_ready;
    assign bus0.copy_y = copy_unit(bus0.copy_a, bus0.copy_select, bus0.copy_neg);
    assign bus1.copy_y = copy_unit(bus1.copy_a, bus1.copy_select, bus1.copy_neg);

    logic [31:0] o_a [2];
    logic [3:0]  o_sel [2];
    logic        o_neg [2];
    logic        o_rdy [2];
    logic        o_vld [2];
    logic [31:0] o_data [2];
    logic        o_err [2];
    assign o_a[0] = bus0.copy_a;          assign o_a[1] = bus1.copy_a;
    assign o_sel[0] = bus0.copy_select;   assign o_sel[1] = bus1.copy_select;
    assign o_neg[0] = bus0.copy_neg;      assign o_neg[1] = bus1.copy_neg;
    assign o_rdy[0] = bus0.req_ready;     assign o_rdy[1] = bus1.req_ready;
    assign o_vld[0] = bus0.rsp_valid;     assign o_vld[1] = bus1.rsp_valid;
    assign o_data[0] = bus0.rsp_data;     assign o_data[1] = bus1.rsp_data;
    assign o_err[0] = bus0.rsp_err;       assign o_err[1] = bus1.rsp_err;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    function automatic bit is_rsvd(input logic [1:0] op, input bit splat_en);
        return (op == 2'b11) || (op == 2'b10 && !splat_en);
    endfunction

    // Source byte feeding result lane i: rotated lane for COPY/MERGE, fixed lane for SPLAT.
    function automatic logic [7:0] src_lane(input logic [1:0] op, input logic [1:0] shift,
                                            input logic [31:0] src, input int i);
        int k;
        k = (op == 2'b10) ? int'(shift) : (i + int'(shift)) % 4;
        return src[8*k +: 8];
    endfunction

    function automatic logic [31:0] ref_a(input logic [1:0] op, input logic [1:0] shift, input logic [31:0] src);
        logic [31:0] a;
        for (int i = 0; i < 4; i++) a[8*i +: 8] = src_lane(op, shift, src, i);
        return a;
    endfunction

    function automatic logic [32:0] ref_rsp(input logic [1:0] op, input logic neg, input logic [3:0] mask,
                                            input logic [1:0] shift, input logic [31:0] src,
                                            input logic [31:0] dst, input bit splat_en);
        logic [31:0] out;
        logic [7:0]  b;
        if (is_rsvd(op, splat_en)) return {1'b1, 32'h0};
        for (int i = 0; i < 4; i++) begin
            b = src_lane(op, shift, src, i);
            if (mask[i])           out[8*i +: 8] = neg ? ~b : b;
            else if (op == 2'b01)  out[8*i +: 8] = dst[8*i +: 8];
            else                   out[8*i +: 8] = 8'h00;
        end
        return {1'b0, out};
    endfunction

    task automatic issue(input logic [1:0] op, input logic neg, input logic [3:0] mask,
                         input logic [1:0] shift, input logic [31:0] src, input logic [31:0] dst);
        for (int d = 0; d < 2; d++) chk("req_ready_idle", d, 32'(o_rdy[d]), 32'd1);
        req_op = op; req_neg = neg; req_mask = mask; req_shift = shift;
        req_src = src; req_dst = dst; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(input logic [1:0] op, input logic neg, input logic [3:0] mask,
                           input logic [1:0] shift, input logic [31:0] src, input logic [31:0] dst,
                           input int bp);
        int          n;
        bit          seen;
        bit          rs;
        logic [32:0] e;
        logic [31:0] held [2];
        rsp_ready = (bp == 0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            for (int d = 0; d < 2; d++) begin
                rs = is_rsvd(op, d == 0);
                if (n == 1) begin
                    chk("p1_select", d, 32'(o_sel[d]), rs ? 32'd0 : 32'(mask));
                    chk("p1_neg", d, 32'(o_neg[d]), rs ? 32'd0 : 32'(neg));
                    chk("p1_a", d, o_a[d], rs ? 32'd0 : ref_a(op, shift, src));
                    chk("p1_ready", d, 32'(o_rdy[d]), 32'd0);
                end
                if (n == 2 && op == 2'b01) begin
                    chk("p2_select", d, 32'(o_sel[d]), 32'(4'(~mask)));
                    chk("p2_neg", d, 32'(o_neg[d]), 32'd0);
                    chk("p2_a", d, o_a[d], dst);
                end
            end
            if (o_vld[0] === 1'b1) seen = 1'b1;
        end
        chk("latency", 0, 32'(n), (op == 2'b01) ? 32'd3 : 32'd2);
        for (int d = 0; d < 2; d++) begin
            e = ref_rsp(op, neg, mask, shift, src, dst, d == 0);
            chk("rsp_valid", d, 32'(o_vld[d]), 32'd1);
            chk("rsp_data", d, o_data[d], e[31:0]);
            chk("rsp_err", d, 32'(o_err[d]), 32'(e[32]));
            chk("done_select", d, 32'(o_sel[d]), 32'd0);
            chk("done_a", d, o_a[d], 32'd0);
            chk("done_neg", d, 32'(o_neg[d]), 32'd0);
            held[d] = o_data[d];
        end
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("bp_valid", d, 32'(o_vld[d]), 32'd1);
                chk("bp_data", d, o_data[d], held[d]);
                chk("bp_ready", d, 32'(o_rdy[d]), 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post_valid", d, 32'(o_vld[d]), 32'd0);
            chk("post_err", d, 32'(o_err[d]), 32'd0);
            chk("post_ready", d, 32'(o_rdy[d]), 32'd1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_ready"}, d, 32'(o_rdy[d]), 32'd1);
            chk({tag, "_valid"}, d, 32'(o_vld[d]), 32'd0);
            chk({tag, "_data"}, d, o_data[d], 32'd0);
            chk({tag, "_err"}, d, 32'(o_err[d]), 32'd0);
            chk({tag, "_a"}, d, o_a[d], 32'd0);
            chk({tag, "_select"}, d, 32'(o_sel[d]), 32'd0);
            chk({tag, "_neg"}, d, 32'(o_neg[d]), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_op, r_shift;
        logic        r_neg;
        logic [3:0]  r_mask;
        logic [31:0] r_src, r_dst;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_neg = 1'b0; req_mask = '0;
        req_shift = '0; req_src = '0; req_dst = '0; rsp_ready = 1'b1;
        #1 chk_reset_vals("reset");
        @(posedge clk);
        #1 chk_reset_vals("reset_held");
        @(negedge clk) reset = 1'b0;
        @(negedge clk);

        issue(2'b00, 1'b0, 4'b0101, 2'd0, 32'h11223344, 32'h0);
        collect(2'b00, 1'b0, 4'b0101, 2'd0, 32'h11223344, 32'h0, 0);

        issue(2'b01, 1'b1, 4'b0011, 2'd0, 32'hAABBCCDD, 32'h01020304);
        collect(2'b01, 1'b1, 4'b0011, 2'd0, 32'hAABBCCDD, 32'h01020304, 0);

        issue(2'b00, 1'b0, 4'hF, 2'd1, 32'h11223344, 32'h0);
        collect(2'b00, 1'b0, 4'hF, 2'd1, 32'h11223344, 32'h0, 0);

        issue(2'b01, 1'b1, 4'h0, 2'd3, 32'h55667788, 32'hCAFEF00D);
        collect(2'b01, 1'b1, 4'h0, 2'd3, 32'h55667788, 32'hCAFEF00D, 0);

        issue(2'b01, 1'b0, 4'hF, 2'd2, 32'h89ABCDEF, 32'h12345678);
        collect(2'b01, 1'b0, 4'hF, 2'd2, 32'h89ABCDEF, 32'h12345678, 0);

        issue(2'b00, 1'b1, 4'h0, 2'd1, 32'hDEADBEEF, 32'h0);
        collect(2'b00, 1'b1, 4'h0, 2'd1, 32'hDEADBEEF, 32'h0, 0);

        issue(2'b10, 1'b0, 4'b1001, 2'd2, 32'h11223344, 32'h0);
        collect(2'b10, 1'b0, 4'b1001, 2'd2, 32'h11223344, 32'h0, 0);

        issue(2'b11, 1'b1, 4'hF, 2'd1, 32'h11223344, 32'hFFFFFFFF);
        collect(2'b11, 1'b1, 4'hF, 2'd1, 32'h11223344, 32'hFFFFFFFF, 0);

        // Backpressure with a competing request held valid throughout.
        issue(2'b00, 1'b0, 4'b0110, 2'd2, 32'hA1B2C3D4, 32'h0);
        req_op = 2'b10; req_neg = 1'b1; req_mask = 4'b1111; req_shift = 2'd3;
        req_src = 32'h5A6B7C8D; req_dst = 32'h0; req_valid = 1'b1;
        collect(2'b00, 1'b0, 4'b0110, 2'd2, 32'hA1B2C3D4, 32'h0, 5);
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect(2'b10, 1'b1, 4'b1111, 2'd3, 32'h5A6B7C8D, 32'h0, 0);

        // Asynchronous reset in the middle of MERGE PASS2.
        issue(2'b01, 1'b0, 4'b1010, 2'd1, 32'h13579BDF, 32'h2468ACE0);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("pre_reset_p2_select", d, 32'(o_sel[d]), 32'h5);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("after_reset_valid", d, 32'(o_vld[d]), 32'd0);
                chk("after_reset_ready", d, 32'(o_rdy[d]), 32'd1);
            end
        end

        for (int t = 0; t < 40; t++) begin
            r_op = 2'($urandom_range(0, 3));
            r_neg = 1'($urandom_range(0, 1));
            r_mask = 4'($urandom_range(0, 15));
            r_shift = 2'($urandom_range(0, 3));
            r_src = $urandom;
            r_dst = $urandom;
            issue(r_op, r_neg, r_mask, r_shift, r_src, r_dst);
            collect(r_op, r_neg, r_mask, r_shift, r_src, r_dst, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
